hazard_stall_unit: RTL

- Pipeline control block that sits directly upstream of the EX-stage forwarding logic.
- Decides each cycle whether each pipeline register loads, holds or is flushed, and whether the PC advances.
- Covers three cases: load-use hazards that forwarding cannot resolve, instruction-cache and data-cache miss stalls, and taken-branch/jump redirects resolved in EX.
- Tracks cache completion across overlapping misses so that no cache request is re-issued or lost.

---
 rtl/hazard_stall_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Pipeline control block sitting directly upstream of the EX-stage forwarding
// logic. Each cycle it decides whether every pipeline register loads, holds or
// is flushed, and whether the PC advances. It covers three cases:
//   - load-use hazards that forwarding cannot resolve,
//   - instruction-cache and data-cache miss stalls,
//   - taken-branch / jump redirects resolved in EX.
// It also tracks cache completion across overlapping misses, so that no cache
// request is re-issued or lost.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   rs1_id_IfId, rs2_id_IfId          source register ids of the ID instruction
//   uses_rs1_IfId, uses_rs2_IfId      ID instruction really reads rs1 / rs2
//   is_store_IfId                     ID instruction is a store
//   rd_id_IdEx                        destination register id of the EX instruction
//   read_mem_IdEx, write_reg_IdEx     EX instruction is a load that writes rd
//   br_taken_Ex                       taken branch / jump in EX (redirect)
//   icache_read, icache_resp          fetch request valid / fetch data valid
//   dcache_req, dcache_resp           MEM data-cache request / completion
//   pc_load .. MemWb_load             pipeline register enables
//   IfId_flush, IdEx_flush            insert a bubble on the next load
//   icache_read_en, dcache_req_en     gated request strobes to the caches
//
// Optional feature, selected by the macro HAZARD_PERF_EN:
//   Adds three saturating counters, each PERF_W bits wide:
//     perf_mem_stall_cnt   cache-miss stall cycles
//     perf_lu_stall_cnt    load-use bubbles
//     perf_flush_cnt       flushes issued
module hazard_stall_unit #(
   parameter int NUM_REGS = 32,
   parameter int PERF_W   = 32,
   localparam int RID_W   = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RID_W-1:0] rs1_id_IfId,
   input  logic [RID_W-1:0] rs2_id_IfId,
   input  logic             uses_rs1_IfId,
   input  logic             uses_rs2_IfId,
   input  logic             is_store_IfId,
   input  logic [RID_W-1:0] rd_id_IdEx,
   input  logic             read_mem_IdEx,
   input  logic             write_reg_IdEx,
   input  logic             br_taken_Ex,
   input  logic             icache_read,
   input  logic             icache_resp,
   input  logic             dcache_req,
   input  logic             dcache_resp,
   output logic             pc_load,
   output logic             IfId_load,
   output logic             IdEx_load,
   output logic             ExMem_load,
   output logic             MemWb_load,
   output logic             IfId_flush,
   output logic             IdEx_flush,
   output logic             icache_read_en,
   output logic             dcache_req_en
`ifdef HAZARD_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_mem_stall_cnt,
   output logic [PERF_W-1:0] perf_lu_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

   // REDIRECT behaves like MEM_WAIT, except that a flush is owed when the
   // stall is released.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   state_t state, next_state;
   logic   armed;
   logic   i_done, d_done, flush_pend, lu_last;
   logic   i_done_next, d_done_next, flush_pend_next, lu_last_next;
   logic   i_busy, d_busy, mem_stall, lu_hazard, redirect;

   // A cache is busy while its request is outstanding and it has not already
   // answered earlier in an overlapping miss.
   assign i_busy    = icache_read & ~icache_resp & ~i_done;
   assign d_busy    = dcache_req & ~dcache_resp & ~d_done;
   assign mem_stall = i_busy | d_busy;

   // Register 0 is hard-wired, so it never creates a dependency. The rs2 of a
   // store is excluded, because its data is forwarded into the MEM write port.
   assign lu_hazard = read_mem_IdEx & write_reg_IdEx & (rd_id_IdEx != '0) &
                      ((uses_rs1_IfId & (rs1_id_IfId == rd_id_IdEx)) |
                       (uses_rs2_IfId & (rs2_id_IfId == rd_id_IdEx) & ~is_store_IfId));

   // Either a live branch in EX, or a branch that was seen during a stall.
   assign redirect  = br_taken_Ex | flush_pend;

   // A cache that has already answered must not see its request again until
   // the whole stall is released.
   assign icache_read_en = armed & icache_read & ~i_done;
   assign dcache_req_en  = armed & dcache_req & ~d_done;

   // State, overlap flags and the pending flush. Nothing moves until the
   // first clock edge after reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         armed      <= 1'b0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         flush_pend <= 1'b0;
         lu_last    <= 1'b0;
      end else begin
         armed      <= 1'b1;
         state      <= next_state;
         i_done     <= i_done_next;
         d_done     <= d_done_next;
         flush_pend <= flush_pend_next;
         lu_last    <= lu_last_next;
      end
   end

   // Next state and register controls.
   // Priority: memory stall > redirect > load-use > normal.
   // lu_last blocks a second bubble for the same load-use pair. It is held
   // across memory stalls, because EX keeps the bubble during a stall.
   always_comb begin
      next_state      = state;
      i_done_next     = i_done;
      d_done_next     = d_done;
      flush_pend_next = flush_pend;
      lu_last_next    = lu_last;
      pc_load         = 1'b0;
      IfId_load       = 1'b0;
      IdEx_load       = 1'b0;
      ExMem_load      = 1'b0;
      MemWb_load      = 1'b0;
      IfId_flush      = 1'b0;
      IdEx_flush      = 1'b0;
      if (!armed) begin
         next_state = RUN;
      end else if (mem_stall) begin
         if (br_taken_Ex) begin
            flush_pend_next = 1'b1;
         end
         next_state = redirect ? REDIRECT : MEM_WAIT;
         if (icache_read & icache_resp & d_busy) begin
            i_done_next = 1'b1;
         end
         if (dcache_req & dcache_resp & i_busy) begin
            d_done_next = 1'b1;
         end
      end else begin
         next_state      = RUN;
         i_done_next     = 1'b0;
         d_done_next     = 1'b0;
         flush_pend_next = 1'b0;
         pc_load         = 1'b1;
         IfId_load       = 1'b1;
         IdEx_load       = 1'b1;
         ExMem_load      = 1'b1;
         MemWb_load      = 1'b1;
         lu_last_next    = 1'b0;
         if (redirect) begin
            IfId_flush = 1'b1;
            IdEx_flush = 1'b1;
         end else if (lu_hazard & ~lu_last) begin
            pc_load      = 1'b0;
            IfId_load    = 1'b0;
            IdEx_flush   = 1'b1;
            lu_last_next = 1'b1;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // Saturating event counters. A load-use bubble is the only case where
   // IdEx is flushed without IfId.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_mem_stall_cnt <= '0;
         perf_lu_stall_cnt  <= '0;
         perf_flush_cnt     <= '0;
      end else begin
         if (armed && mem_stall && (perf_mem_stall_cnt != '1)) begin
            perf_mem_stall_cnt <= perf_mem_stall_cnt + 1'b1;
         end
         if (IdEx_flush && !IfId_flush && (perf_lu_stall_cnt != '1)) begin
            perf_lu_stall_cnt <= perf_lu_stall_cnt + 1'b1;
         end
         if (IfId_flush && (perf_flush_cnt != '1)) begin
            perf_flush_cnt <= perf_flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule
